// File: rtl/nic_eject_sink.sv
// Network-interface receive endpoint: buffers ejected flits in a small FWFT FIFO for the host,
// checks each flit's destination and keeps sticky error flags plus saturating statistics.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module nic_eject_sink #(
  parameter int NUM_ROUTERS    = 25,
  parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
  parameter int ROUTER_ID      = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          nic_input_valid,
  input  logic [`FLIT_DATA_WIDTH-1:0]   nic_input_data,
  output logic                          host_valid,
  output logic [`FLIT_DATA_WIDTH-1:0]   host_data,
  input  logic                          host_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              rx_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          misroute_err,
  output logic [ROUTER_ID_BITS-1:0]     misroute_dest,
  output logic                          overflow_err,
  input  logic                          clear_err
);

  localparam int DW = `FLIT_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ROUTER_ID_BITS-1:0] OWN_ID  = ROUTER_ID_BITS'(ROUTER_ID);
  localparam logic [CW-1:0]             DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    CAP_IDLE     = 1'b0,
    CAP_CAPTURED = 1'b1
  } cap_state_e;

  logic [DW-1:0]             mem_r [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]             count_r;
  logic                      host_valid_r;
  logic [DW-1:0]             host_data_r;
  logic [CNT_W-1:0]          rx_count_r, drop_count_r;
  logic                      misroute_err_r, overflow_err_r;
  logic [ROUTER_ID_BITS-1:0] misroute_dest_r;
  cap_state_e                cap_state_r, cap_state_s;

  logic                      pop_s, push_acc_s, drop_s, misroute_s, capture_s;
  logic [ROUTER_ID_BITS-1:0] dest_s;
  logic [PW-1:0]             rd_ptr_nxt_s;
  logic [CW-1:0]             count_nxt_s;
  logic [DW-1:0]             head_nxt_s;

  // Accept/drop decision, next occupancy and the head flit to present after this edge
  always_comb begin
    pop_s        = host_valid_r & host_ready;
    push_acc_s   = nic_input_valid & ((count_r < DEPTH_C) | pop_s);
    drop_s       = nic_input_valid & ~push_acc_s;
    dest_s       = nic_input_data[DW-1 -: ROUTER_ID_BITS];
    misroute_s   = nic_input_valid & (dest_s != OWN_ID);
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = {DW{1'b0}};
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_acc_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
    // The incoming flit becomes head when it lands in the slot the read pointer moves to.
    if (count_nxt_s == {CW{1'b0}}) begin
      head_nxt_s = {DW{1'b0}};
    end else if (push_acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = nic_input_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Misroute capture FSM: next state and capture strobe
  always_comb begin
    cap_state_s = cap_state_r;
    capture_s   = 1'b0;
    if (clear_err) begin
      cap_state_s = CAP_IDLE;
    end else begin
      case (cap_state_r)
        CAP_IDLE: begin
          if (misroute_s) begin
            cap_state_s = CAP_CAPTURED;
            capture_s   = 1'b1;
          end else begin
            cap_state_s = CAP_IDLE;
          end
        end
        CAP_CAPTURED: cap_state_s = CAP_CAPTURED;
        default:      cap_state_s = CAP_IDLE;
      endcase
    end
  end

  // FIFO storage, pointers, occupancy and registered head outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      host_valid_r <= 1'b0;
      host_data_r  <= {DW{1'b0}};
    end else begin
      if (push_acc_s) begin
        mem_r[wr_ptr_r] <= nic_input_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r     <= rd_ptr_nxt_s;
      count_r      <= count_nxt_s;
      host_valid_r <= (count_nxt_s != {CW{1'b0}});
      host_data_r  <= head_nxt_s;
    end
  end

  // Statistics, sticky flags and misroute capture state; clear_err overrides same-cycle events
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count_r      <= {CNT_W{1'b0}};
      drop_count_r    <= {CNT_W{1'b0}};
      overflow_err_r  <= 1'b0;
      misroute_err_r  <= 1'b0;
      misroute_dest_r <= {ROUTER_ID_BITS{1'b0}};
      cap_state_r     <= CAP_IDLE;
    end else begin
      cap_state_r    <= cap_state_s;
      misroute_err_r <= (cap_state_s == CAP_CAPTURED);
      if (clear_err) begin
        rx_count_r      <= {CNT_W{1'b0}};
        drop_count_r    <= {CNT_W{1'b0}};
        overflow_err_r  <= 1'b0;
        misroute_dest_r <= {ROUTER_ID_BITS{1'b0}};
      end else begin
        if (push_acc_s && (rx_count_r != {CNT_W{1'b1}})) begin
          rx_count_r <= rx_count_r + CNT_W'(1);
        end
        if (drop_s) begin
          overflow_err_r <= 1'b1;
          if (drop_count_r != {CNT_W{1'b1}}) begin
            drop_count_r <= drop_count_r + CNT_W'(1);
          end
        end
        if (capture_s) begin
          misroute_dest_r <= dest_s;
        end
      end
    end
  end

  assign host_valid    = host_valid_r;
  assign host_data     = host_data_r;
  assign fifo_count    = count_r;
  assign rx_count      = rx_count_r;
  assign drop_count    = drop_count_r;
  assign misroute_err  = misroute_err_r;
  assign misroute_dest = misroute_dest_r;
  assign overflow_err  = overflow_err_r;

endmodule

// File: tb/tb_nic_eject_sink.sv
// Directed bench for nic_eject_sink: a queue scoreboard plus a small reference model of the
// counters and flags, compared at every falling edge.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module tb_nic_eject_sink;
  localparam int DW = `FLIT_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          nic_input_valid;
  logic [DW-1:0] nic_input_data;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic [2:0]    fifo_count;
  logic [15:0]   rx_count, drop_count;
  logic          misroute_err, overflow_err;
  logic [4:0]    misroute_dest;
  logic          clear_err;

  logic          sat_valid;
  logic          s_host_valid;
  logic [DW-1:0] s_host_data;
  logic [2:0]    s_fifo_count;
  logic [3:0]    s_rx_count, s_drop_count;
  logic          s_misroute_err, s_overflow_err;
  logic [4:0]    s_misroute_dest;

  always #5 clk = ~clk;

  nic_eject_sink #(.NUM_ROUTERS(25), .ROUTER_ID(7), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .nic_input_valid(nic_input_valid), .nic_input_data(nic_input_data),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .fifo_count(fifo_count), .rx_count(rx_count), .drop_count(drop_count),
    .misroute_err(misroute_err), .misroute_dest(misroute_dest),
    .overflow_err(overflow_err), .clear_err(clear_err)
  );

  nic_eject_sink #(.NUM_ROUTERS(25), .ROUTER_ID(7), .FIFO_DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .nic_input_valid(sat_valid), .nic_input_data(nic_input_data),
    .host_valid(s_host_valid), .host_data(s_host_data), .host_ready(1'b1),
    .fifo_count(s_fifo_count), .rx_count(s_rx_count), .drop_count(s_drop_count),
    .misroute_err(s_misroute_err), .misroute_dest(s_misroute_dest),
    .overflow_err(s_overflow_err), .clear_err(clear_err)
  );

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   m_rx, m_drop;
  logic          m_ovf, m_mis;
  logic [4:0]    m_mdest;
  logic [3:0]    m_sat;
  logic          sat_phase;

  function automatic logic [DW-1:0] flit(input logic [4:0] dest, input logic [26:0] pl);
    return {dest, pl};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_rx = 16'd0; m_drop = 16'd0; m_ovf = 1'b0; m_mis = 1'b0; m_mdest = 5'd0; m_sat = 4'd0;
  endtask

  task automatic check_outputs();
    chk("host_valid", {63'd0, host_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("host_data", {32'd0, host_data}, {32'd0, exp_q[0]});
    chk("fifo_count", {61'd0, fifo_count}, 64'(exp_q.size()));
    chk("rx_count", {48'd0, rx_count}, {48'd0, m_rx});
    chk("drop_count", {48'd0, drop_count}, {48'd0, m_drop});
    chk("overflow_err", {63'd0, overflow_err}, {63'd0, m_ovf});
    chk("misroute_err", {63'd0, misroute_err}, {63'd0, m_mis});
    chk("misroute_dest", {59'd0, misroute_dest}, {59'd0, m_mdest});
    chk("sat_rx_count", {60'd0, s_rx_count}, {60'd0, m_sat});
  endtask

  // One clock: check current outputs, drive inputs, advance the model, take the edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    logic pop, acc;
    @(negedge clk);
    check_outputs();
    nic_input_valid = v; nic_input_data = d; host_ready = r; clear_err = c;
    sat_valid = sat_phase & v;
    pop = (exp_q.size() != 0) && r;
    acc = v && ((exp_q.size() < 4) || pop);
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(d);
    if (c) begin
      model_clear();
    end else begin
      if (acc && m_rx != 16'hFFFF) m_rx = m_rx + 16'd1;
      if (v && !acc) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      if (v && d[DW-1 -: 5] != 5'd7 && !m_mis) begin
        m_mis = 1'b1; m_mdest = d[DW-1 -: 5];
      end
      if (sat_phase && v && m_sat != 4'hF) m_sat = m_sat + 4'd1;
    end
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; nic_input_valid = 1'b0; nic_input_data = {DW{1'b0}};
    host_ready = 1'b1; clear_err = 1'b0; sat_valid = 1'b0; sat_phase = 1'b0;
    model_clear();
    #3;
    check_outputs();
    chk("reset_host_data", {32'd0, host_data}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // basic delivery
    cyc(1'b1, flit(5'd7, 27'h123), 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // fill and overflow, then drain
    for (int i = 1; i <= 6; i++) cyc(1'b1, flit(5'd7, 27'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) cyc(1'b1, flit(5'd7, 27'h10 + 27'(i)), 1'b0, 1'b0);
    cyc(1'b1, flit(5'd7, 27'h20), 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // misroute capture, clear, and clear winning over a same-cycle misroute
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b1, flit(5'd3, 27'h31), 1'b1, 1'b0);
    cyc(1'b1, flit(5'd12, 27'h32), 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b1, flit(5'd9, 27'h41), 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, flit(5'd20, 27'h42), 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // reset pulsed between edges with three flits buffered
    for (int i = 0; i < 3; i++) cyc(1'b1, flit(5'd7, 27'h50 + 27'(i)), 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    nic_input_valid = 1'b0; sat_valid = 1'b0; clear_err = 1'b0;
    reset = 1'b1;
    #1;
    exp_q.delete();
    model_clear();
    check_outputs();
    #2 reset = 1'b0;
    cyc(1'b1, flit(5'd7, 27'h55), 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // counter saturation on the 4-bit instance
    sat_phase = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b1, flit(5'd7, 27'h100 + 27'(i)), 1'b1, 1'b0);
    sat_phase = 1'b0;
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs();
    chk("sat_rx_final", {60'd0, s_rx_count}, 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
